// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address overlay, frame layout and FSM states.
package cpu_types_pkg;

  localparam int unsigned ICACHE_FRAMES = 16;
  localparam int unsigned ICACHE_IDX_W  = $clog2(ICACHE_FRAMES);
  localparam int unsigned ICACHE_TAG_W  = 32 - ICACHE_IDX_W - 2;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage for the direct-mapped icache: one write port, one combinational read port.
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned FRAMES = ICACHE_FRAMES,
  parameter int unsigned IDX_W  = $clog2(FRAMES),
  parameter int unsigned TAG_W  = 32 - IDX_W - 2,
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              WEN,
  input  logic [IDX_W-1:0]  windex,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  rindex,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [WORD_W-1:0] rdata
);

  logic [FRAMES-1:0] valid;
  logic [TAG_W-1:0]  tags  [FRAMES];
  logic [WORD_W-1:0] datas [FRAMES];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid <= '0;
      for (int unsigned i = 0; i < FRAMES; i++) begin
        tags[i]  <= '0;
        datas[i] <= '0;
      end
    end else if (WEN) begin
      valid[windex] <= 1'b1;
      tags[windex]  <= wtag;
      datas[windex] <= wdata;
    end
  end

  always_comb begin
    rvalid = valid[rindex];
    rtag   = tags[rindex];
    rdata  = datas[rindex];
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped one-word-per-block instruction cache with a two-state miss FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int unsigned FRAMES = ICACHE_FRAMES,
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic [WORD_W-1:0] iload,
  input  logic              iwait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(FRAMES);
  localparam int unsigned TAG_W = WORD_W - IDX_W - 2;

  icache_state_t     state, next_state;
  logic [WORD_W-1:0] miss_addr;
  logic              miss_start;
  logic              hit;
  logic              wen;
  logic              fr_valid;
  logic [TAG_W-1:0]  fr_tag;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  assign req_idx = imemaddr[IDX_W+1:2];
  assign req_tag = imemaddr[WORD_W-1:IDX_W+2];

  icache_frame_array #(
    .FRAMES (FRAMES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .WORD_W (WORD_W)
  ) u_frames (
    .CLK    (CLK),
    .nRST   (nRST),
    .WEN    (wen),
    .windex (miss_addr[IDX_W+1:2]),
    .wtag   (miss_addr[WORD_W-1:IDX_W+2]),
    .wdata  (iload),
    .rindex (req_idx),
    .rvalid (fr_valid),
    .rtag   (fr_tag),
    .rdata  (imemload)
  );

  assign hit = imemREN && fr_valid && (fr_tag == req_tag);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      state <= next_state;
      if (miss_start) miss_addr <= imemaddr;
    end
  end

  // The fill is never abandoned: once in FETCH only iwait decides when to leave.
  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    iREN       = 1'b0;
    iaddr      = '0;
    wen        = 1'b0;
    miss_start = 1'b0;
    unique case (state)
      IDLE: begin
        ihit = hit;
        if (imemREN && !hit) begin
          miss_start = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) begin
          wen        = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && hit_count != '1)        hit_count  <= hit_count + 32'd1;
      if (miss_start && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-block instruction cache.
- Sits between the datapath's instruction fetch port (imemREN/imemaddr -> ihit/imemload) and the memory controller's instruction port.
- Responds to datapath fetch requests:
  - hits are served combinationally from a frame array;
  - misses are filled from RAM through a 2-state FSM.
- The datapath stalls its PC on ihit=0, so correctness requires ihit never to assert on stale or invalid data.

Parameters:
FRAMES, 16, number of frames; power of two, >=2; index width IDX_W = $clog2(FRAMES)
WORD_W, 32, instruction and address width

Ports:
CLK  input  1  clock, rising-edge
nRST  input  1  reset, synchronous, active-low
imemREN  input  1  datapath fetch request
imemaddr  input  32  datapath fetch byte address
ihit  output  1  requested word valid on imemload this cycle
imemload  output  32  instruction word
iREN  output  1  read request to memory controller
iaddr  output  32  read address to memory controller
iload  input  32  word returned by memory controller
iwait  input  1  memory controller busy; data valid when iREN=1 and iwait=0

Behaviour:
- Clocking and reset:
  - Single clock CLK.
  - Reset nRST is synchronous, active-low: sampled only on the rising edge of CLK; when low at that edge, all state resets.
- Address split:
  - byte offset = addr[1:0], ignored (word-aligned fetch)
  - index = addr[IDX_W+1:2]
  - tag = addr[31:IDX_W+2]
- Frame array, per frame:
  - valid bit, reset to 0
  - tag register, reset to 0
  - data word, reset to 0
- FSM states: IDLE, FETCH. Reset state is IDLE.
- IDLE:
  - hit = imemREN && valid[index] && tag[index]==tag(imemaddr)
  - ihit = hit, combinational, same cycle
  - imemload = data[index] always; don't-care when ihit=0
  - iREN = 0, iaddr = 0
  - imemREN && !hit -> latch miss_addr <= imemaddr; next state FETCH
  - imemREN=0 -> stay in IDLE, ihit=0
- FETCH:
  - iREN = 1, iaddr = miss_addr (the latched value, stable even if imemaddr changes), ihit = 0
  - iwait=1 -> stay in FETCH
  - iwait=0 -> write frame[index(miss_addr)] = {valid 1, tag(miss_addr), iload}; next state IDLE
  - The fill always completes, even if imemREN drops or imemaddr changes mid-fetch; a RAM read is never aborted.
- Miss latency: the requesting address hits in the cycle after the fill edge. Minimum miss penalty is 2 cycles (miss detect + one FETCH cycle with iwait=0).
- Conflict replacement: a fill to an occupied index overwrites the old tag and data unconditionally.
- Reset values of outputs: ihit=0, iREN=0, iaddr=0, imemload=0 (all frames invalid, zero data).
- Reset asserted mid-FETCH: the FSM returns to IDLE, all valid bits clear, the pending fill is discarded, and iREN is 0 from the following cycle.
- No self-modifying-code coherence: there is no invalidate port, and data writes to instruction space are not seen until reset.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count (32) and miss_count (32), both reset to 0.
  - hit_count increments on every cycle with ihit=1.
  - miss_count increments on each IDLE->FETCH transition.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_types_pkg gains:
  - icachef_t: packed struct {tag, idx, bytoff} overlaying the 32-bit address, for FRAMES=16 (tag 26, idx 4, bytoff 2)
  - icache_frame_t: packed struct {valid, tag, data}
  - ICACHE_FRAMES constant = 16
  - icache_state_t enum {IDLE, FETCH}
- One natural sub-module, icache_frame_array:
  - one write port (windex, wtag, wdata, WEN)
  - one combinational read port (rindex -> valid, tag, data)
  - synchronous active-low reset clearing all frames
- The FSM and hit compare stay in icache_direct.

Test Plan:
- Cold miss:
  - Stimulus: after reset, imemREN=1, imemaddr=0x00000040, RAM holds 0x8C220004, iwait high for 3 cycles.
  - Required: ihit=0 and iREN=1, iaddr=0x40 through FETCH; the next cycle after iwait=0 gives ihit=1, imemload=0x8C220004.
- Warm hit:
  - Stimulus: re-request 0x40.
  - Required: ihit=1 in the same cycle, iREN stays 0.
- Conflict:
  - Stimulus: 0x40 cached, then request 0x80 (same index 0, different tag).
  - Required: miss, fill; afterwards 0x40 misses again.
- Address change mid-fetch:
  - Stimulus: miss on 0x44, imemaddr changed to 0x100 while iwait=1.
  - Required: iaddr stays 0x44; frame 1 is filled with tag(0x44); 0x100 then misses separately.
- Reset mid-fetch:
  - Stimulus: nRST low for one edge during FETCH with iwait=1.
  - Required: iREN=0 the next cycle, ihit=0 for the previously cached 0x40, FSM in IDLE.
- Stats (ICACHE_STATS_EN):
  - Stimulus: the cold-miss then warm-hit sequence.
  - Required: miss_count=1, hit_count=2.
